// File: rtl/asteroid_wave_ctrl.sv
// Wave sequencer and serial BCD score accumulator for NQUAD asteroid quad units.
// Optional feature: define EXTRA_LIFE_EN for the extra_life pulse on 10000-point crossings.
module asteroid_wave_ctrl #(
  parameter int unsigned NQUAD        = 4,
  parameter int unsigned CLEAR_FRAMES = 60
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 vsync,
  input  logic                 game_begin,
  input  logic                 game_over,
  input  logic [NQUAD-1:0]     quad_alive,
  input  logic [NQUAD*11-1:0]  quad_points,
  output logic [NQUAD-1:0]     new_level,
  output logic [NQUAD-1:0]     quad_active,
  output logic [7:0]           level,
  output logic [23:0]          score,
  output logic                 extra_life,
  output logic                 busy_add
);

  localparam int unsigned IW = (NQUAD > 1) ? $clog2(NQUAD) : 1;

  typedef enum logic [2:0] {StIdle, StLaunch, StPlay, StCleared, StOver} state_e;

  state_e          state_q;
  logic            begin_q;
  logic [7:0]      frame_cnt_q;
  logic            begin_rise;
  logic            game_start;
  logic [7:0]      level_next;

  logic            vsync_q;
  logic [NQUAD-1:0] vs_active_q;
  logic [10:0]     pts_q [NQUAD];
  logic [IW-1:0]   idx_q;
  logic [23:0]     score_sum;

  // Quads enabled for a wave: lowest min(level, NQUAD) bits.
  function automatic logic [NQUAD-1:0] level_mask(input logic [7:0] lvl);
    logic [NQUAD-1:0] m;
    int unsigned n;
    n = 32'(lvl[7:4]) * 32'd10 + 32'(lvl[3:0]);
    for (int unsigned i = 0; i < NQUAD; i++) begin
      m[i] = (n > i);
    end
    return m;
  endfunction

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Six-digit BCD ripple add of a points report; clamps to 999999 on carry out.
  function automatic logic [23:0] bcd_add(input logic [23:0] a, input logic [10:0] p);
    logic [23:0] b;
    logic [23:0] s;
    logic        c;
    logic [4:0]  d;
    b = {13'd0, p};
    s = '0;
    c = 1'b0;
    for (int k = 0; k < 6; k++) begin
      d = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'd0, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*k +: 4] = d[3:0];
    end
    return c ? 24'h999999 : s;
  endfunction

  assign begin_rise = game_begin & ~begin_q;
  assign game_start = begin_rise & ~game_over & ((state_q == StIdle) | (state_q == StOver));
  assign level_next = bcd_inc2(level);
  assign score_sum  = bcd_add(score, pts_q[idx_q]);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      begin_q     <= 1'b0;
      frame_cnt_q <= '0;
      level       <= 8'h00;
      new_level   <= '0;
      quad_active <= '0;
    end else begin
      begin_q <= game_begin;
      if (game_over) begin
        state_q     <= StOver;
        new_level   <= '0;
        quad_active <= '0;
      end else begin
        case (state_q)
          StIdle, StOver: begin
            if (begin_rise) begin
              level       <= 8'h01;
              quad_active <= level_mask(8'h01);
              new_level   <= level_mask(8'h01);
              state_q     <= StLaunch;
            end
          end
          StLaunch: begin
            if (vsync) begin
              new_level <= '0;
              state_q   <= StPlay;
            end
          end
          StPlay: begin
            if (vsync && ((quad_alive & quad_active) == '0)) begin
              frame_cnt_q <= '0;
              state_q     <= StCleared;
            end
          end
          StCleared: begin
            if (vsync) begin
              if (frame_cnt_q == 8'(CLEAR_FRAMES - 1)) begin
                level       <= level_next;
                quad_active <= level_mask(level_next);
                new_level   <= level_mask(level_next);
                state_q     <= StLaunch;
              end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Points arrive the cycle after vsync; the active set is the one in force at that vsync,
  // so the final frame before game_over still scores.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vsync_q     <= 1'b0;
      vs_active_q <= '0;
      busy_add    <= 1'b0;
      idx_q       <= '0;
      score       <= '0;
      for (int i = 0; i < int'(NQUAD); i++) pts_q[i] <= '0;
    end else begin
      vsync_q     <= vsync;
      vs_active_q <= quad_active;
      if (game_start) begin
        score    <= '0;
        busy_add <= 1'b0;
      end else if (vsync_q && !busy_add) begin
        for (int i = 0; i < int'(NQUAD); i++) begin
          pts_q[i] <= vs_active_q[i] ? quad_points[i*11 +: 11] : 11'd0;
        end
        busy_add <= 1'b1;
        idx_q    <= '0;
      end else if (busy_add) begin
        score <= score_sum;
        idx_q <= idx_q + IW'(1);
        if (idx_q == IW'(NQUAD - 1)) busy_add <= 1'b0;
      end
    end
  end

`ifdef EXTRA_LIFE_EN
  logic extra_life_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      extra_life_q <= 1'b0;
    end else begin
      extra_life_q <= busy_add & ~game_start & (score_sum[23:16] != score[23:16]);
    end
  end

  assign extra_life = extra_life_q;
`else
  assign extra_life = 1'b0;
`endif

endmodule

// File: tb/tb_asteroid_wave_ctrl.sv
// Bench for asteroid_wave_ctrl: directed game flow plus random points against a decimal game model.
module tb_asteroid_wave_ctrl;

  localparam int unsigned NQ = 4;
  localparam int unsigned CF = 5;

  localparam int MIdle = 0, MLaunch = 1, MPlay = 2, MCleared = 3, MOver = 4;

  logic          clk = 1'b0;
  logic          resetN, vsync, game_begin, game_over;
  logic [NQ-1:0] quad_alive;
  logic [NQ*11-1:0] quad_points;
  logic [NQ-1:0] new_level, quad_active;
  logic [7:0]    level;
  logic [23:0]   score;
  logic          extra_life, busy_add;

  asteroid_wave_ctrl #(.NQUAD(NQ), .CLEAR_FRAMES(CF)) dut (
    .clk(clk), .resetN(resetN), .vsync(vsync), .game_begin(game_begin),
    .game_over(game_over), .quad_alive(quad_alive), .quad_points(quad_points),
    .new_level(new_level), .quad_active(quad_active), .level(level), .score(score),
    .extra_life(extra_life), .busy_add(busy_add)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, el_cnt = 0;
  int m_state, m_level, m_cnt, m_score, m_pulses;

  always @(negedge clk) if (extra_life === 1'b1) el_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    x = v;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] m_active();
    int n;
    if (m_state != MLaunch && m_state != MPlay && m_state != MCleared) return 4'd0;
    n = (m_level < int'(NQ)) ? m_level : int'(NQ);
    return 4'((1 << n) - 1);
  endfunction

  function automatic logic [3:0] m_new_level();
    return (m_state == MLaunch) ? m_active() : 4'd0;
  endfunction

  function automatic int pts_dec(input logic [10:0] p);
    return int'(p[10:8]) * 100 + int'(p[7:4]) * 10;
  endfunction

  function automatic logic [43:0] rand_pts();
    logic [43:0] r;
    for (int i = 0; i < 4; i++) r[i*11 +: 11] = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 9)), 4'd0};
    return r;
  endfunction

  task automatic model_vsync(input logic [3:0] alive, input logic [43:0] pts, input logic go);
    logic [3:0] act;
    int prev;
    act = m_active();
    for (int i = 0; i < 4; i++) begin
      if (act[i]) begin
        prev = m_score;
        m_score = m_score + pts_dec(pts[i*11 +: 11]);
        if (m_score > 999999) m_score = 999999;
`ifdef EXTRA_LIFE_EN
        if (m_score / 10000 != prev / 10000) m_pulses++;
`endif
      end
    end
    if (go) m_state = MOver;
    else if (m_state == MLaunch) m_state = MPlay;
    else if (m_state == MPlay) begin
      if ((alive & act) == 4'd0) begin m_state = MCleared; m_cnt = 0; end
    end else if (m_state == MCleared) begin
      if (m_cnt == int'(CF) - 1) begin
        m_level = (m_level < 99) ? m_level + 1 : 99;
        m_state = MLaunch;
      end else m_cnt++;
    end
  endtask

  task automatic frame(input logic [3:0] alive, input logic [43:0] pts, input logic go);
    @(negedge clk);
    check("new_level_at_vsync", 32'(new_level), 32'(m_new_level()));
    vsync = 1'b1;
    quad_alive = alive;
    if (go) game_over = 1'b1;
    model_vsync(alive, pts, go);
    @(negedge clk);
    vsync = 1'b0;
    quad_points = pts;
    @(negedge clk);
    check("busy_add_start", 32'(busy_add), 32'd1);
    repeat (4) @(negedge clk);
    check("score_at_vsync_plus5", 32'(score), 32'(to_bcd(m_score)));
    check("busy_add_done", 32'(busy_add), 32'd0);
    @(negedge clk);
    check("level", 32'(level), 32'(to_bcd(m_level)));
    check("quad_active", 32'(quad_active), 32'(m_active()));
    check("new_level", 32'(new_level), 32'(m_new_level()));
    check("extra_life_pulses", el_cnt, m_pulses);
  endtask

  task automatic start_game();
    @(negedge clk);
    game_begin = 1'b1;
    if ((m_state == MIdle || m_state == MOver) && !game_over) begin
      m_state = MLaunch; m_level = 1; m_score = 0;
    end
    @(negedge clk);
    check("start_level", 32'(level), 32'(to_bcd(m_level)));
    check("start_active", 32'(quad_active), 32'(m_active()));
    check("start_new_level", 32'(new_level), 32'(m_new_level()));
    check("start_score", 32'(score), 32'(to_bcd(m_score)));
    game_begin = 1'b0;
  endtask

  initial begin
    logic [43:0] p;
    int el_before, lvl_before;
    resetN = 1'b0; vsync = 1'b0; game_begin = 1'b0; game_over = 1'b0;
    quad_alive = '0; quad_points = '0;
    m_state = MIdle; m_level = 0; m_cnt = 0; m_score = 0; m_pulses = 0;
    repeat (3) @(negedge clk);
    check("rst_new_level", 32'(new_level), 32'd0);
    check("rst_quad_active", 32'(quad_active), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_extra_life", 32'(extra_life), 32'd0);
    check("rst_busy_add", 32'(busy_add), 32'd0);
    resetN = 1'b1;

    // Reset in the middle of LAUNCH
    start_game();
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    check("midrst_new_level", 32'(new_level), 32'd0);
    check("midrst_active", 32'(quad_active), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    m_state = MIdle; m_level = 0; m_score = 0;
    frame(4'hF, 44'd0, 1'b0);

    // Game start and first launch
    start_game();
    check("t2_active", 32'(quad_active), 32'h1);
    check("t2_new_level", 32'(new_level), 32'h1);
    frame(4'hF, 44'd0, 1'b0);

    // Climb to level 4 with zero points
    for (int w = 0; w < 3; w++) begin
      frame(4'h0, 44'd0, 1'b0);
      repeat (CF) frame(4'hF, 44'd0, 1'b0);
      if (w == 0) begin
        check("t3_new_level", 32'(new_level), 32'h3);
        check("t3_level", 32'(level), 32'h02);
      end
      frame(4'hF, 44'd0, 1'b0);
    end

    // All four quads report from a zero score
    frame(4'hF, {11'h100, 11'h050, 11'h020, 11'h020}, 1'b0);
    check("t4_score", 32'(score), 32'h000190);

    // Build to 9990, then cross 10000
    repeat (3) frame(4'hF, {4{11'h700}}, 1'b0);
    frame(4'hF, {11'h700, 11'h700, 11'h000, 11'h000}, 1'b0);
    check("t5_pre_score", 32'(score), 32'h009990);
    el_before = el_cnt;
    frame(4'hF, {11'h000, 11'h000, 11'h000, 11'h020}, 1'b0);
    check("t5_score", 32'(score), 32'h010010);
`ifdef EXTRA_LIFE_EN
    check("t5_extra_life", el_cnt - el_before, 1);
`else
    check("t5_extra_life", el_cnt - el_before, 0);
`endif

    // Random frames: random points and alive patterns
    for (int k = 0; k < 24; k++) begin
      p = rand_pts();
      frame(($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)), p, 1'b0);
    end

    // Drive to saturation
    for (int k = 0; k < 330; k++) frame(4'hF, {4{11'h790}}, 1'b0);
    check("sat_score", 32'(score), 32'h999999);

    // game_over on the same vsync as CLEARED -> LAUNCH
    for (int k = 0; k < 20 && m_state != MPlay; k++) frame(4'hF, 44'd0, 1'b0);
    frame(4'h0, 44'd0, 1'b0);
    repeat (CF - 1) frame(4'hF, 44'd0, 1'b0);
    lvl_before = m_level;
    frame(4'hF, rand_pts(), 1'b1);
    check("t6_level", 32'(level), 32'(to_bcd(lvl_before)));
    check("t6_active", 32'(quad_active), 32'd0);
    check("t6_new_level", 32'(new_level), 32'd0);

    // game_begin edge is ignored while game_over is held
    @(negedge clk);
    game_begin = 1'b1;
    @(negedge clk);
    check("over_begin_level", 32'(level), 32'(to_bcd(lvl_before)));
    check("over_begin_active", 32'(quad_active), 32'd0);
    game_begin = 1'b0;
    @(negedge clk);
    game_over = 1'b0;
    @(negedge clk);
    start_game();
    check("restart_score", 32'(score), 32'd0);
    frame(4'h1, rand_pts(), 1'b0);
    frame(4'h1, rand_pts(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
